y_serial_addsub: RTL and testbench
==================================

Y_SERIAL_ADDSUB -- requirements
Module: y_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port ctrl, input, 1 bit: operation select; 0 = add, 1 = subtract (a - b).
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: two's-complement operands.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in; used for add only.
REQ-008 The block SHALL have port z, output, WIDTH bits: result, held until the next completion.
REQ-009 The block SHALL have port cout, output, 1 bit: carry out of the MSB; 0 on subtract means a borrow occurred.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when z and cout become valid.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 On a rising edge in IDLE with start=1, the block SHALL latch a, b, ctrl and cin, clear the bit counter and enter RUN.
REQ-014 The initial carry SHALL be cin when ctrl=0 and 1 when ctrl=1; the b operand SHALL be inverted when ctrl=1.
REQ-015 In RUN, each edge SHALL compute one result bit, LSB first: sum = a[i]^b'[i]^c, with the carry registered for the next bit.
REQ-016 After exactly WIDTH RUN edges, the block SHALL enter DONE and update z and cout together.
REQ-017 DONE SHALL last one cycle with done=1 and then return to IDLE, so done is high on the cycle after the (WIDTH+1)th edge following the start edge.
REQ-018 start SHALL be ignored in RUN and DONE, with no queuing; operand changes after the start edge SHALL have no effect.
REQ-019 Back-to-back requests SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-020 The result SHALL wrap modulo 2^WIDTH.
REQ-021 z and cout SHALL not change except at DONE entry or reset.

Reset
REQ-022 Asserting reset SHALL force IDLE immediately, including mid-RUN, and abort any in-flight operation with no done pulse.
REQ-023 Reset SHALL clear z, cout, busy, done, the counter, the carry and the operand registers to 0.

Configuration
REQ-024 With macro Y_SERIAL_OVERFLOW_FLAG_EN defined, the block SHALL add port ovf, output, 1 bit, defined as the carry into the MSB XOR cout.
REQ-025 ovf SHALL be updated with z at DONE entry and reset to 0.
REQ-026 Without Y_SERIAL_OVERFLOW_FLAG_EN, the ovf port and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-027 Package y_arith_pkg SHALL hold the op encodings (OP_ADD=0, OP_SUB=1), the state encodings (IDLE, RUN, DONE) and the default width constant.
REQ-028 The per-bit sum/carry SHALL be a sub-module y_full_adder (a, b, cin -> z, cout), instantiated once and reused every cycle.
REQ-029 The bit counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=32)
REQ-030 Add: a=5, b=3, ctrl=0, cin=0 -> z=8, cout=0, done exactly one cycle high, 33 edges after the start edge.
REQ-031 Subtract: a=3, b=5, ctrl=1 -> z=0xFFFFFFFE, cout=0; a=5, b=3 -> z=2, cout=1.
REQ-032 Wrap: a=0xFFFFFFFF, b=1, ctrl=0, cin=0 -> z=0, cout=1; with the macro, a=0x7FFFFFFF, b=1 -> z=0x80000000, ovf=1.
REQ-033 Handshake: start pulsed again at RUN cycle 5 with a=1, b=1 -> ignored, result from the first operands, busy continuous for 32 cycles.
REQ-034 Reset at RUN cycle 10 -> busy=0, z=0, no done pulse; a new start 2 cycles after reset release completes correctly.
REQ-035 Oracle: 10 random a, b, ctrl, cin sets -> z and cout match the {cout,z} computed as a+b+cin (add) or a-b (subtract) at every done pulse.

Source files
------------

// File: rtl/y_arith_pkg.sv
// Shared encodings for the serial add/subtract block: operation select,
// FSM states and the default operand width.
package y_arith_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/y_full_adder.sv
// One-bit full adder; the serial datapath reuses a single instance every cycle.
module y_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic z,
  output logic cout
);

  assign z    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/y_serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
// Optional overflow flag output enabled by defining Y_SERIAL_OVERFLOW_FLAG_EN.
module y_serial_addsub
  import y_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_d;
  logic               op_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fa_b;
  logic               fa_z;
  logic               fa_cout;

  // Subtraction is a + ~b + 1: b is inverted bit by bit as it streams out.
  assign fa_b  = b_q[0] ^ op_q;
  assign acc_d = {fa_z, acc_q[WIDTH-1:1]};

  y_full_adder u_fa (
    .a    (a_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .z    (fa_z),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      z       <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= ctrl;
            carry_q <= (ctrl == OP_SUB) ? 1'b1 : cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          acc_q   <= acc_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Last bit: publish result and flags together on DONE entry.
          if (cnt_q == LAST_BIT) begin
            z       <= acc_d;
            cout    <= fa_cout;
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
            ovf     <= carry_q ^ fa_cout;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_serial_addsub.sv
// Directed and randomised-operand bench for y_serial_addsub at WIDTH=32.
// Overflow checks are compiled in when Y_SERIAL_OVERFLOW_FLAG_EN is defined.
module tb_y_serial_addsub;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] z;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] hold_z = '0;
  logic         hold_c = 1'b0;

  y_serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .z     (z),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation; inj > 0 pulses start with a=b=1 after that RUN edge.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic icin, input logic [W-1:0] ez,
                        input logic ecout, input int inj);
    int  n;
    int  busy_cnt;
    bit  hold_ok;
    bit  seen;
    logic [W-1:0] bp;
    bp = ic ? ~ib : ib;
    @(negedge clk);
    a = ia; b = ib; ctrl = ic; cin = icin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ~ib; ctrl = ~ic; cin = ~icin;
    busy_cnt = busy ? 1 : 0;
    hold_ok  = 1'b1;
    seen     = 1'b0;
    n        = 0;
    while (!seen && n < W + 8) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (z !== hold_z || cout !== hold_c) hold_ok = 1'b0;
      end
      if (n == inj) begin
        start = 1'b1; a = 1; b = 1;
      end else if (n == inj + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    // Start edge counts as edge 1, so done appears right after edge W+1.
    chk({tag, "_done_lat"}, n, seen ? W : -1);
    chk({tag, "_busy_len"}, busy_cnt, W);
    chk({tag, "_z_hold"}, hold_ok, 1);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_cout"}, cout, ecout);
`ifdef Y_SERIAL_OVERFLOW_FLAG_EN
    chk({tag, "_ovf"}, ovf, (ia[W-1] == bp[W-1]) && (ez[W-1] != ia[W-1]));
`endif
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
    hold_z = ez;
    hold_c = ecout;
  endtask

  logic [W-1:0] ra, rb;
  logic         rc, rcin;
  logic [W:0]   ref_sum;

  initial begin
    reset = 1'b1; start = 1'b0; ctrl = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", z, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add5_3",   32'd5,          32'd3, 1'b0, 1'b0, 32'd8,          1'b0, -1);
    run_op("sub3_5",   32'd3,          32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE,  1'b0, -1);
    run_op("sub5_3",   32'd5,          32'd3, 1'b1, 1'b1, 32'd2,          1'b1, -1);
    run_op("wrap",     32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, 32'd0,          1'b1, -1);
    run_op("ovf_pos",  32'h7FFF_FFFF,  32'd1, 1'b0, 1'b0, 32'h8000_0000,  1'b0, -1);
    run_op("add_cin",  32'd10,         32'd20, 1'b0, 1'b1, 32'd31,        1'b0, -1);
    run_op("ignore",   32'h1234_0000,  32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 5);

    // Abort mid-run: reset clears outputs immediately and no done follows.
    @(negedge clk);
    a = 32'hDEAD_0000; b = 32'h0000_BEEF; ctrl = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_z", z, 0);
    chk("abort_done", done, 0);
    hold_z = '0;
    hold_c = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    run_op("after_rst", 32'd100, 32'd23, 1'b1, 1'b0, 32'd77, 1'b1, -1);

    for (int i = 0; i < 10; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      if (rc) ref_sum = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
      else    ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rcin};
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rcin, ref_sum[W-1:0], ref_sum[W], -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
